// File: rtl/dmac_pkg.sv
// Shared types and register-map constants for the multi-channel DMA controller.
package dmac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } dmac_state_e;

    localparam logic [1:0] REG_BASE   = 2'b00;
    localparam logic [1:0] REG_COUNT  = 2'b01;
    localparam logic [1:0] REG_MODE   = 2'b10;
    localparam logic [1:0] REG_GLOBAL = 2'b11;

    localparam int MODE_DIR      = 0;
    localparam int MODE_BURST    = 1;
    localparam int MODE_AUTOINIT = 2;
    localparam int MODE_EN       = 3;
    localparam int GLB_ROTATE    = 0;

    typedef struct packed {
        logic en;
        logic autoinit;
        logic burst;
        logic dir;
    } mode_t;

    function automatic mode_t decode_mode(input logic [3:0] raw);
        mode_t m;
        m.en       = raw[MODE_EN];
        m.autoinit = raw[MODE_AUTOINIT];
        m.burst    = raw[MODE_BURST];
        m.dir      = raw[MODE_DIR];
        return m;
    endfunction

endpackage

// File: rtl/dmac_arbiter.sv
// Fixed / rotating priority encoder over the eligible-channel vector.
// Latency: grant is combinational; the last-grant pointer updates on take.
// Backpressure: none, the caller samples the grant only when it can accept it.
module dmac_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           rotate,
    input  logic           take,
    output logic           gnt_vld,
    output logic [CW-1:0]  gnt_idx
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);
    localparam logic [CW:0]   NCH_W    = (CW + 1)'(NCH);

    logic [CW-1:0]  last_gnt;
    logic [CW-1:0]  start;
    logic [CW-1:0]  off;
    logic [CW:0]    sum;
    logic [NCH-1:0] req_rot;

    // Rotate the request vector so the search starts just past the last grant.
    always_comb begin
        start = '0;
        if (rotate) start = (last_gnt == LAST_IDX) ? '0 : last_gnt + 1'b1;
        req_rot = NCH'({req, req} >> start);
        gnt_vld = |req;
        off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) off = CW'(i);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= NCH_W) sum = sum - NCH_W;
        gnt_idx = sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= '0;
        end else if (take) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/dmac_multichannel.sv
// Multi-channel DMA controller: arbitrates DREQ lines, holds the bus via HLD/HLDA, moves IO<->memory.
// Latency: HLD one edge after an eligible request, DACK/strobes one edge after HLDA, one transfer per RDY cycle.
// Backpressure: RDY low stretches the transfer; HLDA low mid-transfer aborts it without register update.
module dmac_multichannel
    import dmac_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int DW  = 8,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] DREQ,
    input  logic           HLDA,
    input  logic           RDY,
    input  logic           REGW,
    input  logic [CW+1:0]  REGSEL,
    input  logic [AW-1:0]  Setup,
    input  logic [DW-1:0]  Data_in,
    output logic           HLD,
    output logic [NCH-1:0] DACK,
    output logic           MEMR,
    output logic           MEMW,
    output logic           IOR,
    output logic           IOW,
    output logic [NCH-1:0] EOP,
    output logic [AW-1:0]  Addrbus,
    output logic [DW-1:0]  Data_out
);

    dmac_state_e    state;
    logic [CW-1:0]  chan;
    logic           rotate;
    logic [AW-1:0]  base_sh [NCH];
    logic [AW-1:0]  cnt_sh  [NCH];
    logic [AW-1:0]  addr_r  [NCH];
    logic [AW-1:0]  cnt_r   [NCH];
    mode_t          mode_r  [NCH];

    logic [NCH-1:0] elig;
    logic [NCH-1:0] chan_oh;
    logic           gnt_vld;
    logic [CW-1:0]  gnt_idx;
    logic           take;

    logic [AW-1:0]  cur_addr;
    logic [AW-1:0]  cur_cnt;
    mode_t          cur_mode;
    logic [AW-1:0]  nxt_addr;
    logic [AW-1:0]  nxt_cnt;
    logic           term;
    logic           burst_go;

    logic [CW-1:0]  wr_ch;
    logic [1:0]     wr_reg;
    logic           wr_blocked;

    always_comb begin
        elig    = '0;
        chan_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = mode_r[i].en && (cnt_r[i] != '0) && DREQ[i];
        end
        chan_oh[chan] = 1'b1;
    end

    assign take     = (state == ST_IDLE) && gnt_vld;
    assign cur_addr = addr_r[chan];
    assign cur_cnt  = cnt_r[chan];
    assign cur_mode = mode_r[chan];
    assign nxt_addr = cur_addr + 1'b1;
    assign nxt_cnt  = cur_cnt - 1'b1;
    assign term     = (nxt_cnt == '0);
    // Terminal count always closes a burst, even when autoinit reloads the count.
    assign burst_go = cur_mode.burst && DREQ[chan] && !term;

    assign wr_ch      = REGSEL[CW+1:2];
    assign wr_reg     = REGSEL[1:0];
    assign wr_blocked = (state != ST_IDLE) && (wr_ch == chan);

    dmac_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (elig),
        .rotate  (rotate),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            chan     <= '0;
            rotate   <= 1'b0;
            HLD      <= 1'b0;
            DACK     <= '0;
            MEMR     <= 1'b0;
            MEMW     <= 1'b0;
            IOR      <= 1'b0;
            IOW      <= 1'b0;
            EOP      <= '0;
            Addrbus  <= '0;
            Data_out <= '0;
            for (int i = 0; i < NCH; i++) begin
                base_sh[i] <= '0;
                cnt_sh[i]  <= '0;
                addr_r[i]  <= '0;
                cnt_r[i]   <= '0;
                mode_r[i]  <= '0;
            end
        end else begin
            EOP <= '0;

            if (REGW) begin
                if (wr_reg == REG_GLOBAL) begin
                    rotate <= Setup[GLB_ROTATE];
                end else if (!wr_blocked) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (wr_ch == CW'(i)) begin
                            case (wr_reg)
                                REG_BASE:  begin base_sh[i] <= Setup; addr_r[i] <= Setup; end
                                REG_COUNT: begin cnt_sh[i]  <= Setup; cnt_r[i]  <= Setup; end
                                REG_MODE:  mode_r[i] <= decode_mode(Setup[3:0]);
                                default:   ;
                            endcase
                        end
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        chan  <= gnt_idx;
                        state <= ST_REQ;
                        HLD   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!DREQ[chan]) begin
                        state <= ST_IDLE;
                        HLD   <= 1'b0;
                    end else if (HLDA) begin
                        state   <= ST_XFER;
                        DACK    <= chan_oh;
                        Addrbus <= cur_addr;
                        MEMR    <= cur_mode.dir;
                        IOW     <= cur_mode.dir;
                        IOR     <= !cur_mode.dir;
                        MEMW    <= !cur_mode.dir;
                    end
                end
                ST_XFER: begin
                    if (!HLDA) begin
                        state   <= ST_IDLE;
                        HLD     <= 1'b0;
                        DACK    <= '0;
                        {MEMR, MEMW, IOR, IOW} <= 4'b0000;
                        Addrbus <= '0;
                    end else if (RDY) begin
                        Data_out <= Data_in;
                        if (term) begin
                            EOP <= chan_oh;
                            if (cur_mode.autoinit) begin
                                addr_r[chan] <= base_sh[chan];
                                cnt_r[chan]  <= cnt_sh[chan];
                            end else begin
                                addr_r[chan]    <= nxt_addr;
                                cnt_r[chan]     <= '0;
                                mode_r[chan].en <= 1'b0;
                            end
                        end else begin
                            addr_r[chan] <= nxt_addr;
                            cnt_r[chan]  <= nxt_cnt;
                        end
                        if (burst_go) begin
                            Addrbus <= nxt_addr;
                        end else begin
                            state   <= ST_IDLE;
                            HLD     <= 1'b0;
                            DACK    <= '0;
                            {MEMR, MEMW, IOR, IOW} <= 4'b0000;
                            Addrbus <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
